// File: rtl/user_io_router.sv
// Wishbone-controlled pad router: per-pad source select between core channels
// and software drive, plus synchronised inputs with edge-triggered pending bits.
module user_io_router #(
    parameter int          NPADS       = 38,
    parameter int          NCHAN       = 4,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADR    = 32'h3000_0000
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rstn_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    input  logic [NCHAN*NPADS-1:0] ch_out,
    input  logic [NCHAN*NPADS-1:0] ch_oeb,
    input  logic [NPADS-1:0]       io_in,
    output logic [NPADS-1:0]       io_out,
    output logic [NPADS-1:0]       io_oeb,
    output logic                   irq
);

    logic [3:0]       r_src [NPADS];
    logic [3:0]       r_ctl [NPADS];
    logic [2:0]       r_cnt;
    logic             r_ack;
    logic [31:0]      r_dat;
    logic [NPADS-1:0] r_s1, r_s2, r_prev, r_pend;
    logic [NPADS-1:0] r_out, r_oeb;
    logic             r_irq;

    logic             w_req, w_fire, w_base, w_wr, w_cfg_hit;
    logic [9:0]       w_word, w_off;
    logic [5:0]       w_idx;
    logic [31:0]      w_mask, w_rdata;
    logic [63:0]      w_sync64, w_pend64, w_clr64;
    logic [NPADS-1:0] w_set, w_out, w_oeb;
    logic             w_unused;

    assign w_req     = wbs_cyc_i & wbs_stb_i & ~r_ack;
    assign w_fire    = w_req && (r_cnt == 3'(WAIT_STATES));
    assign w_base    = (wbs_adr_i[31:12] == BASE_ADR[31:12]);
    assign w_wr      = w_fire & wbs_we_i & w_base;
    assign w_word    = wbs_adr_i[11:2];
    assign w_off     = w_word - 10'h040;
    assign w_idx     = w_off[5:0];
    assign w_cfg_hit = w_base && (w_word >= 10'h040) && (w_word < 10'(64 + NPADS));
    assign w_mask    = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                        {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w_sync64  = 64'(r_s2);
    assign w_pend64  = 64'(r_pend);
    assign w_unused  = ^{wbs_adr_i[1:0], w_off[9:6]};

    always_comb begin
        w_rdata = 32'h0;
        if (w_base) begin
            unique case (1'b1)
                w_word == 10'h000: w_rdata = w_sync64[31:0];
                w_word == 10'h001: w_rdata = w_sync64[63:32];
                w_word == 10'h002: w_rdata = w_pend64[31:0];
                w_word == 10'h003: w_rdata = w_pend64[63:32];
                default: begin
                    for (int p = 0; p < NPADS; p++)
                        if (w_cfg_hit && w_idx == p[5:0])
                            w_rdata = {20'h0, r_ctl[p], 4'h0, r_src[p]};
                end
            endcase
        end
    end

    // Writes of 1 clear the matching pending bits; byte lanes honour sel.
    always_comb begin
        w_clr64 = 64'h0;
        if (w_wr && w_word == 10'h002) w_clr64[31:0]  = wbs_dat_i & w_mask;
        if (w_wr && w_word == 10'h003) w_clr64[63:32] = wbs_dat_i & w_mask;
    end

    always_comb begin
        for (int p = 0; p < NPADS; p++) begin
            w_set[p] = (r_s2[p] & ~r_prev[p] & r_ctl[p][2]) |
                       (~r_s2[p] & r_prev[p] & r_ctl[p][3]);
            w_out[p] = r_ctl[p][0];
            w_oeb[p] = r_ctl[p][1];
            for (int c = 0; c < NCHAN; c++) begin
                if (r_src[p] == 4'(c)) begin
                    w_out[p] = ch_out[c*NPADS + p];
                    w_oeb[p] = ch_oeb[c*NPADS + p];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_cnt <= 3'd0;
            r_ack <= 1'b0;
            r_dat <= 32'h0;
        end else begin
            r_ack <= w_fire;
            r_dat <= (w_fire && !wbs_we_i) ? w_rdata : 32'h0;
            if (!w_req || w_fire) r_cnt <= 3'd0;
            else                  r_cnt <= r_cnt + 3'd1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            for (int p = 0; p < NPADS; p++) begin
                r_src[p] <= 4'hF;
                r_ctl[p] <= 4'b0010;
            end
        end else begin
            for (int p = 0; p < NPADS; p++) begin
                if (w_wr && w_cfg_hit && w_idx == p[5:0]) begin
                    if (wbs_sel_i[0]) r_src[p] <= wbs_dat_i[3:0];
                    if (wbs_sel_i[1]) r_ctl[p] <= wbs_dat_i[11:8];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
            r_pend <= '0;
            r_irq  <= 1'b0;
            r_out  <= '0;
            r_oeb  <= '1;
        end else begin
            r_s1   <= io_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_pend <= (r_pend & ~w_clr64[NPADS-1:0]) | w_set;
            r_irq  <= |r_pend;
            r_out  <= w_out;
            r_oeb  <= w_oeb;
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign io_out    = r_out;
    assign io_oeb    = r_oeb;
    assign irq       = r_irq;

endmodule

// File: tb/tb_user_io_router.sv
// Directed bench for user_io_router with default parameters.
// Immediate assertions compare each observation against hand-derived values.
module tb_user_io_router;

    localparam int NP = 38;
    localparam int NC = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]      sel = 4'h0;
    logic [31:0]     adr = '0, dat = '0;
    logic            ack;
    logic [31:0]     dat_o;
    logic [NC*NP-1:0] ch_out = '0;
    logic [NC*NP-1:0] ch_oeb = '1;
    logic [NP-1:0]   io_in = '0;
    logic [NP-1:0]   io_out, io_oeb;
    logic            irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;
    int lat;

    always #5 clk = ~clk;

    user_io_router dut (
        .wb_clk_i(clk), .wb_rstn_i(rstn),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .ch_out(ch_out), .ch_oeb(ch_oeb),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] r, output int l);
        logic got;
        got = 1'b0;
        r = '0;
        l = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            l++;
            if (ack) begin
                r = dat_o;
                got = 1'b1;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk("ack_seen", 64'(got), 64'd1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        int l;
        wb(1'b1, a, d, s, r, l);
    endtask

    task automatic rdw(input logic [31:0] a, output logic [31:0] r);
        int l;
        wb(1'b0, a, 32'h0, 4'hF, r, l);
    endtask

    function automatic logic [31:0] cfga(input int p);
        return BASE + 32'h100 + 32'(4 * p);
    endfunction

    initial begin
        #12;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_dat", 64'(dat_o), 64'd0);
        chk("rst_out", 64'(io_out), 64'd0);
        chk("rst_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        chk("rst_irq", 64'(irq), 64'd0);
        @(negedge clk); rstn = 1'b1;

        wb(1'b0, cfga(5), 32'h0, 4'hF, rd, lat);
        chk("cfg5_rst", 64'(rd), 64'h20F);
        chk("latency", 64'(lat), 64'd2);
        @(posedge clk); #1;
        chk("dat_idle", 64'(dat_o), 64'd0);

        io_in[1] = 1'b1; io_in[37] = 1'b1;
        repeat (3) @(posedge clk);
        rdw(BASE + 32'h000, rd);
        chk("in_lo", 64'(rd), 64'h2);
        rdw(BASE + 32'h004, rd);
        chk("in_hi", 64'(rd), 64'h20);
        io_in[1] = 1'b0; io_in[37] = 1'b0;

        ch_out[2*NP+3] = 1'b1;
        ch_oeb[2*NP+3] = 1'b0;
        wr(cfga(3), 32'h2, 4'hF);
        @(posedge clk); #1;
        chk("ch2_out", 64'(io_out[3]), 64'd1);
        chk("ch2_oeb", 64'(io_oeb[3]), 64'd0);
        @(negedge clk); ch_out[2*NP+3] = 1'b0;
        @(posedge clk); #1;
        chk("ch2_follow", 64'(io_out[3]), 64'd0);
        ch_oeb = '1;
        wr(cfga(3), 32'h109, 4'hF);
        @(posedge clk); #1;
        chk("sw_out", 64'(io_out[3]), 64'd1);
        chk("sw_oeb", 64'(io_oeb[3]), 64'd0);
        wr(cfga(4), 32'h104, 4'hF);
        ch_out[0*NP+4] = 1'b0;
        @(posedge clk); #1;
        chk("src_nchan", 64'({io_out[4], io_oeb[4]}), 64'b10);

        wr(cfga(7), 32'h60F, 4'hF);
        @(negedge clk); io_in[7] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("irq_set", 64'(irq), 64'd1);
        rdw(BASE + 32'h008, rd);
        chk("pend_lo", 64'(rd), 64'h80);
        wr(BASE + 32'h008, 32'h80, 4'hF);
        @(posedge clk); #1;
        chk("irq_clr", 64'(irq), 64'd0);
        @(negedge clk); io_in[7] = 1'b0;
        repeat (5) @(posedge clk);
        rdw(BASE + 32'h008, rd);
        chk("no_fall", 64'(rd), 64'h0);
        @(negedge clk); io_in[7] = 1'b1;
        wr(BASE + 32'h008, 32'h80, 4'hF);
        rdw(BASE + 32'h008, rd);
        chk("set_wins", 64'(rd), 64'h80);

        wr(cfga(0), 32'hFFFF_FFFF, 4'b0010);
        rdw(cfga(0), rd);
        chk("sel_byte", 64'(rd), 64'hF0F);

        wr(BASE + 32'h050, 32'hFFFF_FFFF, 4'hF);
        rdw(BASE + 32'h050, rd);
        chk("unmapped", 64'(rd), 64'h0);
        wr(BASE + 32'h1000 + 32'h114, 32'h0, 4'hF);
        rdw(BASE + 32'h1000 + 32'h114, rd);
        chk("base_miss", 64'(rd), 64'h0);
        rdw(cfga(5), rd);
        chk("cfg5_kept", 64'(rd), 64'h20F);
        rdw(cfga(NP), rd);
        chk("cfg_npads", 64'(rd), 64'h0);

        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = cfga(3); sel = 4'hF;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("rst_mid_ack", 64'(ack), 64'd0);
        chk("rst_mid_out", 64'(io_out), 64'd0);
        chk("rst_mid_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        chk("rst_mid_irq", 64'(irq), 64'd0);
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_no_ack", 64'(ack), 64'd0);
        @(negedge clk); rstn = 1'b1;
        rdw(cfga(3), rd);
        chk("cfg3_rst", 64'(rd), 64'h20F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
